// File: rtl/blink_period_meter.sv
// Blink period meter: synchronizes an external square wave and measures its
// rise-to-rise period and rise-to-fall high time in clk cycles.
module blink_period_meter #(
    parameter int CNT_W       = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             overflow
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MEAS = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_s_d;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hcap;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_high;
    logic                   r_valid;
    logic                   r_locked;
    logic                   r_overflow;

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    // Edge pulses are registered so the FSM sees a clean one-cycle strobe;
    // this extra stage sets the input-to-valid latency at SYNC_STAGES+2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_s_d  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
            r_s_d  <= w_s;
            r_rise <= w_rise;
            r_fall <= w_fall;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hcap     <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_hcap     <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (r_rise) begin
                        r_cnt   <= CNT_ONE;
                        r_hcap  <= '0;
                        r_state <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (r_rise) begin
                        r_period <= r_cnt;
                        r_high   <= r_hcap;
                        r_valid  <= 1'b1;
                        r_locked <= 1'b1;
                        r_cnt    <= CNT_ONE;
                        r_hcap   <= '0;
                    end else if (r_cnt == CNT_MAX) begin
                        // Give up before the counter wraps; last results are kept.
                        r_overflow <= 1'b1;
                        r_locked   <= 1'b0;
                        r_cnt      <= '0;
                        r_hcap     <= '0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                        if (r_fall) begin
                            r_hcap <= r_cnt;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign period    = r_period;
    assign high_time = r_high;
    assign valid     = r_valid;
    assign locked    = r_locked;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_blink_period_meter.sv
// Directed bench for blink_period_meter: one default-width instance and one
// 8-bit instance used for the saturation scenario.
module tb_blink_period_meter;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        sig_in = 1'b0;
    logic        clr    = 1'b0;
    logic        sig8   = 1'b0;
    logic        clr8   = 1'b0;

    logic [25:0] period;
    logic [25:0] high_time;
    logic        valid;
    logic        locked;
    logic        overflow;

    logic [7:0]  period8;
    logic [7:0]  high8;
    logic        valid8;
    logic        locked8;
    logic        overflow8;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int c0       = 0;
    int vp[$];
    int vh[$];
    int vt[$];
    int v8p[$];
    int v8h[$];

    always #5 clk = ~clk;

    blink_period_meter u_dut (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig_in),
        .clr       (clr),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .overflow  (overflow)
    );

    blink_period_meter #(.CNT_W(8), .SYNC_STAGES(2)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .sig_in    (sig8),
        .clr       (clr8),
        .period    (period8),
        .high_time (high8),
        .valid     (valid8),
        .locked    (locked8),
        .overflow  (overflow8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            vp.push_back(int'(period));
            vh.push_back(int'(high_time));
            vt.push_back(cyc);
        end
        if (valid8 === 1'b1) begin
            v8p.push_back(int'(period8));
            v8h.push_back(int'(high8));
        end
    endtask

    task automatic wave(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            sig_in = ((i % p) < h);
            step();
        end
    endtask

    task automatic wave8(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) begin
            sig8 = ((i % p) < h);
            step();
        end
    endtask

    task automatic clearq();
        vp.delete();
        vh.delete();
        vt.delete();
        v8p.delete();
        v8h.delete();
    endtask

    initial begin
        // Reset held with the input toggling.
        for (int i = 0; i < 3; i++) begin
            sig_in = (i % 2 == 0);
            sig8   = (i % 2 == 0);
            step();
            chk("rst_hold", 64'({period, high_time, valid, locked, overflow}), 64'(0));
            chk("rst_hold8", 64'({period8, high8, valid8, locked8, overflow8}), 64'(0));
        end
        rst    = 1'b0;
        sig_in = 1'b0;
        sig8   = 1'b0;
        step();
        chk("rst_release", 64'({period, high_time, valid, locked, overflow}), 64'(0));
        for (int i = 0; i < 4; i++) step();

        // Divide-by-16 LED wave: period 16, high 8.
        clearq();
        c0 = cyc;
        wave(16, 8, 80);
        chk("w16_count", 64'(vp.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            chk("w16_period", 64'(qat(vp, i)), 64'(16));
            chk("w16_high", 64'(qat(vh, i)), 64'(8));
        end
        chk("w16_latency", 64'(qat(vt, 0) - c0), 64'(20));
        chk("w16_spacing", 64'(qat(vt, 1) - qat(vt, 0)), 64'(16));
        chk("w16_spacing3", 64'(qat(vt, 3) - qat(vt, 2)), 64'(16));
        chk("w16_locked", 64'(locked), 64'(1));

        // Clear between measurements.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_outs", 64'({period, high_time, valid, locked, overflow}), 64'(0));
        for (int i = 0; i < 4; i++) step();

        // Period 10/high 3, then switch to 7/1.
        clearq();
        wave(10, 3, 50);
        wave(7, 1, 14);
        chk("sw_count", 64'(vp.size()), 64'(6));
        for (int i = 0; i < 5; i++) begin
            chk("sw_p10", 64'(qat(vp, i)), 64'(10));
            chk("sw_h3", 64'(qat(vh, i)), 64'(3));
        end
        chk("sw_p7", 64'(qat(vp, 5)), 64'(7));
        chk("sw_h1", 64'(qat(vh, 5)), 64'(1));

        // clr lands on the same edge the FSM would take a rise.
        clearq();
        chk("clr_rise_pre_locked", 64'(locked), 64'(1));
        sig_in = 1'b1;
        step();
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_rise_outs", 64'({period, high_time, valid, locked, overflow}), 64'(0));
        for (int i = 0; i < 3; i++) step();
        sig_in = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("clr_rise_novalid", 64'(vp.size()), 64'(0));
        wave(12, 6, 16);
        chk("p12_count", 64'(vp.size()), 64'(1));
        chk("p12_period", 64'(qat(vp, 0)), 64'(12));
        chk("p12_high", 64'(qat(vh, 0)), 64'(6));

        // 8-bit counter: lock at 20, then starve until saturation.
        clearq();
        for (int j = 0; j < 300; j++) begin
            sig8 = ((j % 20) < 5) && (j < 25);
            step();
            if (j == 277) begin
                chk("sat_pre_ovf", 64'(overflow8), 64'(0));
                chk("sat_pre_locked", 64'(locked8), 64'(1));
            end
            if (j == 278) begin
                chk("sat_ovf", 64'(overflow8), 64'(1));
                chk("sat_locked", 64'(locked8), 64'(0));
                chk("sat_period_hold", 64'(period8), 64'(20));
            end
        end
        chk("sat_valid_count", 64'(v8p.size()), 64'(1));
        chk("sat_first_p", 64'(qat(v8p, 0)), 64'(20));
        chk("sat_first_h", 64'(qat(v8h, 0)), 64'(5));
        clearq();
        wave8(20, 5, 45);
        chk("post_sat_count", 64'(v8p.size()), 64'(2));
        for (int i = 0; i < 2; i++) begin
            chk("post_sat_p", 64'(qat(v8p, i)), 64'(20));
            chk("post_sat_h", 64'(qat(v8h, i)), 64'(5));
        end
        chk("post_sat_ovf_sticky", 64'(overflow8), 64'(1));
        chk("post_sat_locked", 64'(locked8), 64'(1));

        // Asynchronous reset in the middle of a measurement.
        chk("arst_pre_locked", 64'(locked), 64'(1));
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_outs", 64'({period, high_time, valid, locked, overflow}), 64'(0));
        chk("arst_outs8", 64'({period8, high8, valid8, locked8, overflow8}), 64'(0));
        @(posedge clk);
        #1;
        rst    = 1'b0;
        sig_in = 1'b0;
        sig8   = 1'b0;
        clearq();
        wave(12, 6, 12);
        chk("arst_first_rise_novalid", 64'(vp.size()), 64'(0));
        chk("arst_locked", 64'(locked), 64'(0));
        chk("arst_period", 64'(period), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
